// File: rtl/ins_sequencer.sv
// Program sequencer for the 19-bit instruction ROM: runs NOP/HALT/LOOP locally and issues
// all other opcodes to the datapath over valid/ready. Define INS_SEQ_STEP_EN for single-step fetch.
module ins_sequencer #(
    parameter int ADDR_W   = 8,
    parameter int INS_W    = 19,
    parameter int PROG_LEN = 67
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
`ifdef INS_SEQ_STEP_EN
    input  logic              step,
`endif
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] ins_addr,
    input  logic [INS_W-1:0]  ins_read,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [2:0]        op_code,
    output logic [1:0]        op_mode,
    output logic [6:0]        op_a,
    output logic [6:0]        op_b,
    output logic [7:0]        loop_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE, S_DONE} state_t;

    localparam logic [2:0]        OPC_NOP  = 3'b000;
    localparam logic [2:0]        OPC_HALT = 3'b001;
    localparam logic [2:0]        OPC_LOOP = 3'b010;
    localparam logic [ADDR_W-1:0] PC_END   = ADDR_W'(PROG_LEN);

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] loop_addr_q;
    logic              loop_act_q;
    logic [7:0]        loop_cnt_q;
    logic              busy_q, done_q, err_q, op_valid_q;
    logic [2:0]        op_code_q;
    logic [1:0]        op_mode_q;
    logic [6:0]        op_a_q, op_b_q;

    logic [2:0]        opc;
    logic [7:0]        loop_n;
    logic [ADDR_W-1:0] loop_t;
    logic [ADDR_W-1:0] pc_inc;
    logic              loop_fault;
    logic              fetch_en;

`ifdef INS_SEQ_STEP_EN
    assign fetch_en = step;
`else
    assign fetch_en = 1'b1;
`endif

    assign opc    = ins_read[18:16];
    assign loop_n = ins_read[13:6];
    assign loop_t = ADDR_W'(ins_read[5:0]);
    assign pc_inc = pc_q + ADDR_W'(1);
    // A backward target is mandatory; a second LOOP address while one is active is nesting.
    assign loop_fault = (loop_t >= pc_q) || (loop_act_q && (pc_q != loop_addr_q));

    // NOTE: asynchronous reset returns every register (op_valid included) to idle at once;
    // all state updates are non-blocking so decode always sees the pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            loop_addr_q <= '0;
            loop_act_q  <= 1'b0;
            loop_cnt_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            op_valid_q  <= 1'b0;
            op_code_q   <= '0;
            op_mode_q   <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        pc_q       <= '0;
                        done_q     <= 1'b0;
                        err_q      <= 1'b0;
                        loop_act_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (fetch_en) begin
                        if (pc_q == PC_END) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            case (opc)
                                OPC_NOP: pc_q <= pc_inc;
                                OPC_HALT: begin
                                    state_q <= S_DONE;
                                    done_q  <= 1'b1;
                                    busy_q  <= 1'b0;
                                end
                                OPC_LOOP: begin
                                    if (loop_fault) begin
                                        err_q   <= 1'b1;
                                        state_q <= S_DONE;
                                        done_q  <= 1'b1;
                                        busy_q  <= 1'b0;
                                    end else if (!loop_act_q) begin
                                        if (loop_n == 8'd0) begin
                                            pc_q <= pc_inc;
                                        end else begin
                                            loop_cnt_q  <= loop_n - 8'd1;
                                            loop_act_q  <= 1'b1;
                                            loop_addr_q <= pc_q;
                                            pc_q        <= loop_t;
                                        end
                                    end else if (loop_cnt_q == 8'd0) begin
                                        loop_act_q <= 1'b0;
                                        pc_q       <= pc_inc;
                                    end else begin
                                        loop_cnt_q <= loop_cnt_q - 8'd1;
                                        pc_q       <= loop_t;
                                    end
                                end
                                default: begin
                                    op_code_q  <= opc;
                                    op_mode_q  <= ins_read[15:14];
                                    op_a_q     <= ins_read[13:7];
                                    op_b_q     <= ins_read[6:0];
                                    op_valid_q <= 1'b1;
                                    pc_q       <= pc_inc;
                                    state_q    <= S_ISSUE;
                                end
                            endcase
                        end
                    end
                end
                S_ISSUE: begin
                    if (op_valid_q && op_ready) begin
                        op_valid_q <= 1'b0;
                        state_q    <= S_FETCH;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign ins_addr = pc_q;
    assign op_valid = op_valid_q;
    assign op_code  = op_code_q;
    assign op_mode  = op_mode_q;
    assign op_a     = op_a_q;
    assign op_b     = op_b_q;
    assign loop_cnt = loop_cnt_q;

endmodule

// File: tb/tb_ins_sequencer.sv
// Self-checking bench for ins_sequencer: ROM model, expected-op scoreboard and
// directed scenarios for latency, loops, back-pressure, loop faults and a full program.
module tb_ins_sequencer;

    localparam int ADDR_W   = 8;
    localparam int INS_W    = 19;
    localparam int PROG_LEN = 67;
    localparam logic [18:0] HALT_W = 19'h10000;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              busy, done, err;
    logic [ADDR_W-1:0] ins_addr;
    logic [INS_W-1:0]  ins_read;
    logic              op_valid;
    logic              op_ready;
    logic [2:0]        op_code;
    logic [1:0]        op_mode;
    logic [6:0]        op_a, op_b;
    logic [7:0]        loop_cnt;

    logic [18:0] rom [0:255];
    logic [18:0] exp_q [$];
    int checks = 0;
    int errors = 0;
    int accepts = 0;
    bit rand_ready = 1'b0;

    always #5 clk = ~clk;

    assign ins_read = rom[ins_addr];

    ins_sequencer #(.ADDR_W(ADDR_W), .INS_W(INS_W), .PROG_LEN(PROG_LEN)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
`ifdef INS_SEQ_STEP_EN
        .step     (1'b1),
`endif
        .busy     (busy),
        .done     (done),
        .err      (err),
        .ins_addr (ins_addr),
        .ins_read (ins_read),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .op_code  (op_code),
        .op_mode  (op_mode),
        .op_a     (op_a),
        .op_b     (op_b),
        .loop_cnt (loop_cnt)
    );

    // op_ready only changes just after a rising edge, so the negedge view equals the edge view.
    always @(posedge clk) begin
        #1;
        if (rand_ready) op_ready = 1'($urandom_range(0, 1));
    end

    always @(negedge clk) begin
        if (!rst && op_valid && op_ready) begin
            logic [18:0] e;
            accepts++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL op_unexpected: got %h, expected none", {op_code, op_mode, op_a, op_b});
            end else begin
                e = exp_q.pop_front();
                if ({op_code, op_mode, op_a, op_b} !== e) begin
                    errors++;
                    $display("FAIL op_fields: got %h, expected %h", {op_code, op_mode, op_a, op_b}, e);
                end
            end
        end
    end

    function automatic logic [18:0] dp(input logic [2:0] c, input logic [1:0] m,
                                       input logic [6:0] a, input logic [6:0] b);
        return {c, m, a, b};
    endfunction

    function automatic logic [18:0] lp(input logic [7:0] n, input logic [5:0] t);
        return {3'b010, 2'b00, n, t};
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = HALT_W;
    endtask

    task automatic do_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Independent interpreter of the program semantics; pushes every op it would issue.
    task automatic model_run(output bit m_err);
        int pc, cnt, la, n, t;
        bit act;
        logic [18:0] w;
        pc = 0; cnt = 0; la = 0; act = 0; m_err = 0;
        for (int guard = 0; guard < 20000; guard++) begin
            if (pc == PROG_LEN) break;
            w = rom[pc];
            if (w[18:16] == 3'b000) pc++;
            else if (w[18:16] == 3'b001) break;
            else if (w[18:16] == 3'b010) begin
                n = int'(w[13:6]);
                t = int'(w[5:0]);
                if (t >= pc || (act && pc != la)) begin m_err = 1; break; end
                if (!act) begin
                    if (n == 0) pc++;
                    else begin cnt = n - 1; act = 1; la = pc; pc = t; end
                end else if (cnt == 0) begin act = 0; pc++; end
                else begin cnt--; pc = t; end
            end else begin
                exp_q.push_back(w);
                pc++;
            end
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({busy, done, err, op_valid, ins_addr, op_code, op_mode, op_a, op_b, loop_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_state: got b%b d%b e%b v%b pc%0d lc%0d, expected all zero",
                     busy, done, err, op_valid, ins_addr, loop_cnt);
        end
    endtask

    task automatic test_reset_mid_issue();
        bit seen = 0;
        clear_rom();
        rom[0] = dp(3'b100, 2'b11, 7'd9, 7'd9);
        op_ready = 1'b0;
        do_start();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (op_valid) begin seen = 1; break; end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL rst_mid_issue_valid: got op_valid=0, expected 1 within 20 cycles");
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({op_valid, busy, ins_addr} !== '0) begin
            errors++;
            $display("FAIL rst_async: got v=%b busy=%b pc=%0d, expected 0 0 0", op_valid, busy, ins_addr);
        end
        @(negedge clk); #1 rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_latency();
        clear_rom();
        rom[0] = 19'h00000;
        rom[1] = dp(3'b101, 2'b01, 7'd3, 7'd0);
        exp_q.push_back(rom[1]);
        op_ready = 1'b1;
        do_start();
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) begin
                checks++;
                if (busy !== 1'b1) begin errors++; $display("FAIL lat_busy: got %b, expected 1", busy); end
            end
            if (c == 2 || c == 3) begin
                checks++;
                if (op_valid !== (c == 3)) begin
                    errors++;
                    $display("FAIL lat_valid_c%0d: got %b, expected %b", c, op_valid, c == 3);
                end
            end
            if (c == 4 || c == 5) begin
                checks++;
                if ({done, busy} !== ((c == 5) ? 2'b10 : 2'b01)) begin
                    errors++;
                    $display("FAIL lat_done_c%0d: got done=%b busy=%b", c, done, busy);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL lat_ops_left: got %0d pending, expected 0", exp_q.size());
        end
    endtask

    task automatic test_loop();
        logic [7:0] lc_exp [0:5];
        int idx = 0;
        bit ok = 0;
        lc_exp = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd0, 8'd0};
        clear_rom();
        rom[0] = 19'h00000;
        rom[1] = dp(3'b011, 2'b00, 7'd1, 7'd11);
        rom[2] = dp(3'b111, 2'b10, 7'd2, 7'd22);
        rom[3] = lp(8'd2, 6'd1);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(rom[1]);
            exp_q.push_back(rom[2]);
        end
        op_ready = 1'b1;
        do_start();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (op_valid && op_ready && idx < 6) begin
                checks++;
                if (loop_cnt !== lc_exp[idx]) begin
                    errors++;
                    $display("FAIL loop_cnt_op%0d: got %0d, expected %0d", idx, loop_cnt, lc_exp[idx]);
                end
                idx++;
            end
            if (done) begin ok = 1; break; end
        end
        checks++;
        if (!ok || idx != 6 || exp_q.size() != 0 || ins_addr !== 8'd4 || err !== 1'b0) begin
            errors++;
            $display("FAIL loop_end: got done=%b ops=%0d left=%0d pc=%0d err=%b, expected 1 6 0 4 0",
                     ok, idx, exp_q.size(), ins_addr, err);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int acc0;
        logic [18:0] w = dp(3'b110, 2'b10, 7'd5, 7'd9);
        clear_rom();
        rom[0] = w;
        exp_q.push_back(w);
        op_ready = 1'b0;
        do_start();
        @(negedge clk);
        @(negedge clk);
        acc0 = accepts;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (!op_valid || {op_code, op_mode, op_a, op_b} !== w || ins_addr !== 8'd1) begin
                errors++;
                $display("FAIL bp_hold_c%0d: got v=%b op=%h pc=%0d, expected 1 %h 1",
                         i, op_valid, {op_code, op_mode, op_a, op_b}, ins_addr, w);
            end
            @(negedge clk);
        end
        @(posedge clk); #1 op_ready = 1'b1;
        wait_done(50, ok);
        checks++;
        if (!ok || accepts - acc0 != 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL bp_accept: got done=%b accepts=%0d, expected 1 1", ok, accepts - acc0);
        end
    endtask

    task automatic test_loop_fault();
        bit ok;
        int acc0;
        clear_rom();
        rom[0] = dp(3'b101, 2'b00, 7'd7, 7'd1);
        rom[1] = 19'h00000;
        rom[2] = 19'h00000;
        rom[3] = 19'h00000;
        rom[4] = lp(8'd1, 6'd5);
        rom[5] = dp(3'b100, 2'b00, 7'd8, 7'd8);
        exp_q.push_back(rom[0]);
        op_ready = 1'b1;
        acc0 = accepts;
        do_start();
        wait_done(100, ok);
        repeat (3) @(negedge clk);
        checks++;
        if (!ok || err !== 1'b1 || done !== 1'b1 || accepts - acc0 != 1) begin
            errors++;
            $display("FAIL loop_fault: got done=%b err=%b ops=%0d, expected 1 1 1", ok, err, accepts - acc0);
        end
        exp_q.push_back(rom[0]);
        do_start();
        @(negedge clk);
        checks++;
        if ({err, done, busy} !== 3'b001) begin
            errors++;
            $display("FAIL fault_clear: got err=%b done=%b busy=%b, expected 0 0 1", err, done, busy);
        end
        wait_done(100, ok);
        exp_q.delete();
    endtask

    task automatic test_full_program();
        bit ok, m_err;
        int acc0, n_exp;
        clear_rom();
        for (int i = 0; i < PROG_LEN; i++) begin
            if ($urandom_range(0, 9) == 0) rom[i] = 19'h00000;
            else rom[i] = dp(3'($urandom_range(3, 7)), 2'($urandom), 7'($urandom), 7'($urandom));
        end
        rom[40] = lp(8'd3, 6'd30);
        rom[60] = lp(8'd0, 6'd10);
        model_run(m_err);
        n_exp = exp_q.size();
        acc0 = accepts;
        rand_ready = 1'b1;
        do_start();
        repeat (20) @(negedge clk);
        do_start();
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || ins_addr === 8'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL start_while_busy: got busy=%b pc=%0d done=%b, expected 1 nonzero 0",
                     busy, ins_addr, done);
        end
        wait_done(5000, ok);
        rand_ready = 1'b0;
        checks++;
        if (!ok || m_err || err !== 1'b0 || ins_addr !== 8'(PROG_LEN)
            || accepts - acc0 != n_exp || exp_q.size() != 0) begin
            errors++;
            $display("FAIL full_prog: got done=%b err=%b pc=%0d ops=%0d, expected 1 0 %0d %0d",
                     ok, err, ins_addr, accepts - acc0, PROG_LEN, n_exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        op_ready = 1'b0;
        clear_rom();
        #22 rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_reset_mid_issue();
        test_latency();
        test_loop();
        test_backpressure();
        test_loop_fault();
        test_full_program();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
